turbo_enc_tx: RTL and testbench

//  Rate-1/3 turbo encoder and transmitter: the sending end of the Deco decoder's input interface.

---
 rtl/turbo_pkg.sv | 46 ++++
 rtl/rsc_enc.sv | 46 ++++
 rtl/turbo_enc_tx.sv | 179 +++++++++++++++++
 tb/tb_turbo_enc_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// -----------------------------------------------------------------------------
// turbo_pkg
// Shared definitions for the rate-1/3 turbo encoder/transmitter and the
// matching decoder: frame geometry, interleaver table, codeword field
// offsets, FSM state type and the soft-symbol mapping.
// -----------------------------------------------------------------------------
package turbo_pkg;

    localparam int K         = 5;   // message bits
    localparam int SYM_W     = 4;   // soft symbol width (two's complement)
    localparam int BEAT_W    = 21;  // output beat width
    localparam int NUM_BEATS = 4;   // beats per frame
    localparam int CW_LEN    = 21;  // coded bits per frame
    localparam int SOFT_W    = CW_LEN * SYM_W;

    // Interleaver: encoder 2 sees msg[PI[i]] on ENC cycle i. Element 0 is the
    // rightmost entry of the concatenation.
    localparam logic [K-1:0][2:0] PI = {3'd2, 3'd1, 3'd4, 3'd0, 3'd3};

    // Codeword field offsets (5-bit so they index cw directly without widening)
    localparam logic [4:0] P1_LO  = 5'd5;   // p1[4:0]
    localparam logic [4:0] P2_LO  = 5'd10;  // p2[4:0]
    localparam logic [4:0] TU1_LO = 5'd15;  // encoder-1 tail inputs
    localparam logic [4:0] TP1_LO = 5'd17;  // encoder-1 tail parity
    localparam logic [4:0] TP2_LO = 5'd19;  // encoder-2 tail parity

    // Last count value of each counted phase
    localparam logic [2:0] ENC_LAST  = 3'd4;
    localparam logic [2:0] TAIL_LAST = 3'd1;
    localparam logic [2:0] SEND_LAST = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        ENC,
        TAIL,
        SEND,
        HOLD
    } state_t;

    // Coded 0 -> +mag, coded 1 -> -mag
    function automatic logic [SYM_W-1:0] soft_map(input logic c,
                                                  input logic [SYM_W-1:0] mag);
        return c ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/rsc_enc.sv
// -----------------------------------------------------------------------------
// rsc_enc
// Bit-serial recursive systematic convolutional encoder, memory 2.
//   a = u ^ s1 ^ s2 ; p = a ^ s2 ; s1' = a ; s2' = s1
// In tail mode the input is replaced by s1 ^ s2 so the feedback term a is 0
// and two tail steps drive the state back to zero.
// Ports:
//   clk_p_i    clock, rising edge
//   reset_p_i  asynchronous active-high reset (clears the state)
//   en         advance the state on this edge
//   tail       termination step (u ignored)
//   u          input bit
//   s_out      current state {s1, s2}
//   p_out      parity bit for the current step (combinational)
// -----------------------------------------------------------------------------
module rsc_enc (
    input  logic       clk_p_i,
    input  logic       reset_p_i,
    input  logic       en,
    input  logic       tail,
    input  logic       u,
    output logic [1:0] s_out,
    output logic       p_out
);

    logic s1_q;
    logic s2_q;
    logic u_eff;
    logic a;

    assign u_eff = tail ? (s1_q ^ s2_q) : u;
    assign a     = u_eff ^ s1_q ^ s2_q;
    assign p_out = a ^ s2_q;
    assign s_out = {s1_q, s2_q};

    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else if (en) begin
            s1_q <= a;
            s2_q <= s1_q;
        end
    end

endmodule

// File: rtl/turbo_enc_tx.sv
// -----------------------------------------------------------------------------
// turbo_enc_tx
// Rate-1/3 turbo encoder and transmitter feeding the decoder input interface.
// A 5-bit message is encoded by two RSC encoders (the second through the
// interleaver), terminated, soft-mapped to 21 four-bit symbols and sent as
// four 21-bit beats. start_o stays high from the first beat until done_i.
// Ports:
//   clk_p_i    clock, rising edge
//   reset_p_i  asynchronous active-high reset
//   valid_i    message valid (accepted when valid_i & ready_o)
//   msg_i      message, msg_i[i] is the i-th bit in time order
//   ready_o    high only in IDLE
//   start_o    decoder start, high during SEND and HOLD
//   data_o     current beat (zero outside SEND/HOLD)
//   done_i     decoder done, only honoured in HOLD
//   busy_o     ~ready_o
// Parameter SOFT_MAG: symbol magnitude 1..7.
// -----------------------------------------------------------------------------
module turbo_enc_tx
    import turbo_pkg::*;
#(
    parameter int SOFT_MAG = 7
) (
    input  logic              clk_p_i,
    input  logic              reset_p_i,
    input  logic              valid_i,
    input  logic [K-1:0]      msg_i,
    output logic              ready_o,
    output logic              start_o,
    output logic [BEAT_W-1:0] data_o,
    input  logic              done_i,
    output logic              busy_o
);

    localparam logic [SYM_W-1:0] MAG = SOFT_MAG[SYM_W-1:0];

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [CW_LEN-1:0]   cw_q, cw_d;

    logic [K-1:0]        msg_w;
    logic [4:0]          cnt5;
    logic                enc_en;
    logic                enc_tail;
    logic                u1, u2;
    logic                p1, p2;
    logic [1:0]          s1_vec, s2_vec;
    logic                tail_u1;
    logic                unused_s2;

    logic [SOFT_W-1:0]   soft_w;
    logic [BEAT_W-1:0]   beat [NUM_BEATS];

    // The systematic field doubles as the message store for the encoders.
    assign msg_w    = cw_q[K-1:0];
    assign cnt5     = {2'b00, cnt_q};
    assign enc_en   = (state_q == ENC) || (state_q == TAIL);
    assign enc_tail = (state_q == TAIL);
    assign u1       = msg_w[cnt_q];
    assign u2       = msg_w[PI[cnt_q]];
    // Tail input of encoder 1 is transmitted; it equals s1 ^ s2.
    assign tail_u1  = s1_vec[1] ^ s1_vec[0];
    // Encoder 2's tail input is not part of the codeword.
    assign unused_s2 = ^s2_vec;

    rsc_enc u_rsc1 (
        .clk_p_i   (clk_p_i),
        .reset_p_i (reset_p_i),
        .en        (enc_en),
        .tail      (enc_tail),
        .u         (u1),
        .s_out     (s1_vec),
        .p_out     (p1)
    );

    rsc_enc u_rsc2 (
        .clk_p_i   (clk_p_i),
        .reset_p_i (reset_p_i),
        .en        (enc_en),
        .tail      (enc_tail),
        .u         (u2),
        .s_out     (s2_vec),
        .p_out     (p2)
    );

    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cw_q    <= cw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cw_d    = cw_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    cw_d          = '0;
                    cw_d[K-1:0]   = msg_i;
                    cnt_d         = '0;
                    state_d       = ENC;
                end
            end
            ENC: begin
                cw_d[P1_LO + cnt5] = p1;
                cw_d[P2_LO + cnt5] = p2;
                if (cnt_q == ENC_LAST) begin
                    cnt_d   = '0;
                    state_d = TAIL;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            TAIL: begin
                cw_d[TU1_LO + cnt5] = tail_u1;
                cw_d[TP1_LO + cnt5] = p1;
                cw_d[TP2_LO + cnt5] = p2;
                if (cnt_q == TAIL_LAST) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            SEND: begin
                if (cnt_q == SEND_LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HOLD: begin
                if (done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Soft symbols: symbol k occupies soft_w[4k+3:4k]
    genvar gi;
    generate
        for (gi = 0; gi < CW_LEN; gi++) begin : g_sym
            assign soft_w[gi*SYM_W +: SYM_W] = soft_map(cw_q[gi], MAG);
        end
        // Beats cut the soft word at 21-bit boundaries, so some symbols
        // straddle two beats.
        for (gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
            assign beat[gi] = soft_w[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    // Outputs decode straight from the state register so reset clears them
    // immediately.
    always_comb begin
        data_o = '0;
        case (state_q)
            SEND:    data_o = beat[cnt_q[1:0]];
            HOLD:    data_o = beat[NUM_BEATS-1];
            default: data_o = '0;
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = ~ready_o;
    assign start_o = (state_q == SEND) || (state_q == HOLD);

endmodule

// File: tb/tb_turbo_enc_tx.sv
// -----------------------------------------------------------------------------
// tb_turbo_enc_tx
// Self-checking bench for turbo_enc_tx. Two instances share all inputs: one
// with SOFT_MAG=7 and one with SOFT_MAG=3. Expected codewords come from a
// model that runs the encoder recurrences over bit arrays.
// -----------------------------------------------------------------------------
module tb_turbo_enc_tx;

    logic        clk_p_i;
    logic        reset_p_i;
    logic        valid_i;
    logic [4:0]  msg_i;
    logic        done_i;
    logic        ready_o, start_o, busy_o;
    logic [20:0] data_o;
    logic        ready3_o, start3_o, busy3_o;
    logic [20:0] data3_o;

    int checks;
    int failures;

    typedef struct packed {
        logic            acc;
        logic [10:0]     st7;
        logic [10:0]     st3;
        logic [3:0][20:0] b7;
        logic [3:0][20:0] b3;
        logic            hold_ok;
        logic            post_start;
        logic            post_ready;
        logic            post_busy;
        logic [20:0]     post_data;
        logic            post_start3;
    } frame_t;

    turbo_enc_tx #(.SOFT_MAG(7)) dut (
        .clk_p_i   (clk_p_i),
        .reset_p_i (reset_p_i),
        .valid_i   (valid_i),
        .msg_i     (msg_i),
        .ready_o   (ready_o),
        .start_o   (start_o),
        .data_o    (data_o),
        .done_i    (done_i),
        .busy_o    (busy_o)
    );

    turbo_enc_tx #(.SOFT_MAG(3)) dut3 (
        .clk_p_i   (clk_p_i),
        .reset_p_i (reset_p_i),
        .valid_i   (valid_i),
        .msg_i     (msg_i),
        .ready_o   (ready3_o),
        .start_o   (start3_o),
        .data_o    (data3_o),
        .done_i    (done_i),
        .busy_o    (busy3_o)
    );

    initial clk_p_i = 1'b0;
    always #5 clk_p_i = ~clk_p_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [20:0] model_cw(input logic [4:0] m);
        logic [2:0] pi [5];
        logic [6:0] uu [2];
        logic [6:0] pp [2];
        logic       s1, s2, a;
        logic [20:0] c;
        pi = '{3'd3, 3'd0, 3'd4, 3'd1, 3'd2};
        for (int e = 0; e < 2; e++) begin
            s1 = 1'b0;
            s2 = 1'b0;
            for (int t = 0; t < 7; t++) begin
                if (t < 5) uu[e][t] = (e == 0) ? m[t] : m[pi[t]];
                else       uu[e][t] = s1 ^ s2;
                a        = uu[e][t] ^ s1 ^ s2;
                pp[e][t] = a ^ s2;
                s2       = s1;
                s1       = a;
            end
        end
        c        = '0;
        c[4:0]   = m;
        c[9:5]   = pp[0][4:0];
        c[14:10] = pp[1][4:0];
        c[16:15] = uu[0][6:5];
        c[18:17] = pp[0][6:5];
        c[20:19] = pp[1][6:5];
        return c;
    endfunction

    function automatic logic [83:0] model_soft(input logic [20:0] c, input int mag);
        logic [83:0] w;
        logic [3:0]  pos;
        logic [3:0]  neg;
        pos = 4'(mag);
        neg = 4'(16 - mag);
        for (int k = 0; k < 21; k++) w[4*k +: 4] = c[k] ? neg : pos;
        return w;
    endfunction

    // Decoder stand-in: the sign of each systematic symbol is the hard bit.
    function automatic logic [4:0] hard_decode(input logic [83:0] w);
        logic [4:0] d;
        for (int i = 0; i < 5; i++) d[i] = w[4*i + 3];
        return d;
    endfunction

    // Drives one frame and records what the two instances produce.
    // Accept edge ends cycle T; samples are taken 1 time unit after edges.
    task automatic run_frame(input logic [4:0] m, input int dly, input bit glitch,
                             input bit hold_v, output frame_t f);
        int n;
        f = '0;
        @(negedge clk_p_i);
        valid_i = 1'b1;
        msg_i   = m;
        n = 0;
        while (!ready_o && n < 64) begin
            @(negedge clk_p_i);
            n++;
        end
        if (!ready_o) begin
            valid_i = 1'b0;
            return;
        end
        @(posedge clk_p_i);
        #1;
        f.acc = 1'b1;
        if (hold_v) msg_i = 5'($urandom);
        else        valid_i = 1'b0;
        // cycles T+1 .. T+11
        for (int k = 0; k < 11; k++) begin
            f.st7[k] = start_o;
            f.st3[k] = start3_o;
            if (k >= 7) begin
                f.b7[k-7] = data_o;
                f.b3[k-7] = data3_o;
            end
            done_i = glitch && (k == 1 || k == 8);
            @(posedge clk_p_i);
            #1;
        end
        // HOLD from T+12
        f.hold_ok = 1'b1;
        for (int d = 0; d <= dly; d++) begin
            if (!(start_o && busy_o && data_o === f.b7[3] &&
                  start3_o && data3_o === f.b3[3]))
                f.hold_ok = 1'b0;
            done_i = (d == dly);
            @(posedge clk_p_i);
            #1;
        end
        done_i        = 1'b0;
        f.post_start  = start_o;
        f.post_ready  = ready_o;
        f.post_busy   = busy_o;
        f.post_data   = data_o;
        f.post_start3 = start3_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_p_i = 1'b1;
        repeat (3) @(posedge clk_p_i);
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        checks++; if (start_o !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", start_o); end
        checks++; if (data_o !== 21'h0) begin failures++; $display("FAIL reset_data: got %h want 0", data_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (start3_o !== 1'b0 || data3_o !== 21'h0) begin failures++; $display("FAIL reset_dut3: start %b data %h want 0 0", start3_o, data3_o); end
        @(negedge clk_p_i);
        reset_p_i = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_zero_msg();
        frame_t f;
        logic [83:0] w;
        run_frame(5'b00000, 2, 1'b0, 1'b0, f);
        w = f.b7;
        checks++; if (f.acc !== 1'b1) begin failures++; $display("FAIL zero_accept: got %b want 1", f.acc); end
        checks++; if (f.st7 !== 11'h780) begin failures++; $display("FAIL zero_start_timing: got %h want 780", f.st7); end
        checks++; if (f.b7[0] !== 21'h177777) begin failures++; $display("FAIL zero_beat0: got %h want 177777", f.b7[0]); end
        checks++; if (w !== model_soft(21'h0, 7)) begin failures++; $display("FAIL zero_word: got %h want %h", w, model_soft(21'h0, 7)); end
        checks++; if (f.hold_ok !== 1'b1) begin failures++; $display("FAIL zero_hold: got %b want 1", f.hold_ok); end
        checks++; if (f.post_start !== 1'b0 || f.post_ready !== 1'b1) begin failures++; $display("FAIL zero_done: start %b ready %b want 0 1", f.post_start, f.post_ready); end
        checks++; if (f.post_data !== 21'h0 || f.post_busy !== 1'b0) begin failures++; $display("FAIL zero_idle_out: data %h busy %b want 0 0", f.post_data, f.post_busy); end
        $display("test_zero_msg beat0=%h", f.b7[0]);
    endtask

    task automatic test_single_one();
        frame_t f;
        logic [83:0] w;
        run_frame(5'b00001, 0, 1'b0, 1'b0, f);
        w = f.b7;
        checks++; if (w !== model_soft(21'h173AE1, 7)) begin failures++; $display("FAIL one_word_const: got %h want %h", w, model_soft(21'h173AE1, 7)); end
        checks++; if (w !== model_soft(model_cw(5'b00001), 7)) begin failures++; $display("FAIL one_word_model: got %h want %h", w, model_soft(model_cw(5'b00001), 7)); end
        checks++; if (f.b7[0][3:0] !== 4'b1001 || f.b7[0][7:4] !== 4'b0111) begin failures++; $display("FAIL one_sym01: got %b %b want 1001 0111", f.b7[0][3:0], f.b7[0][7:4]); end
        checks++; if (f.post_ready !== 1'b1) begin failures++; $display("FAIL one_done: ready %b want 1", f.post_ready); end
        $display("test_single_one word=%h", w);
    endtask

    task automatic test_done_ignored();
        frame_t f;
        logic [4:0] m;
        logic [83:0] w;
        m = 5'($urandom);
        run_frame(m, 3, 1'b1, 1'b0, f);
        w = f.b7;
        checks++; if (f.st7 !== 11'h780) begin failures++; $display("FAIL glitch_timing: got %h want 780", f.st7); end
        checks++; if (f.hold_ok !== 1'b1) begin failures++; $display("FAIL glitch_hold: got %b want 1", f.hold_ok); end
        checks++; if (w !== model_soft(model_cw(m), 7)) begin failures++; $display("FAIL glitch_word: msg %b got %h want %h", m, w, model_soft(model_cw(m), 7)); end
        checks++; if (f.post_ready !== 1'b1 || f.post_start !== 1'b0) begin failures++; $display("FAIL glitch_done: ready %b start %b want 1 0", f.post_ready, f.post_start); end
        $display("test_done_ignored msg=%b", m);
    endtask

    task automatic test_reset_mid_send();
        frame_t f;
        logic [4:0]  m;
        logic [83:0] wexp;
        logic [83:0] w;
        m    = 5'($urandom);
        wexp = model_soft(model_cw(m), 7);
        @(negedge clk_p_i);
        valid_i = 1'b1;
        msg_i   = m;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_pre_ready: got %b want 1", ready_o); end
        @(posedge clk_p_i);
        #1;
        valid_i = 1'b0;
        repeat (9) begin
            @(posedge clk_p_i);
            #1;
        end
        // now in cycle T+10, beat 2
        checks++; if (start_o !== 1'b1 || data_o !== wexp[62:42]) begin failures++; $display("FAIL rst_beat2: start %b data %h want 1 %h", start_o, data_o, wexp[62:42]); end
        #2;
        reset_p_i = 1'b1;
        #1;
        checks++; if (start_o !== 1'b0) begin failures++; $display("FAIL rst_async_start: got %b want 0", start_o); end
        checks++; if (data_o !== 21'h0) begin failures++; $display("FAIL rst_async_data: got %h want 0", data_o); end
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b1) begin failures++; $display("FAIL rst_async_busy: busy %b ready %b want 0 1", busy_o, ready_o); end
        checks++; if (start3_o !== 1'b0 || busy3_o !== 1'b0) begin failures++; $display("FAIL rst_async_dut3: start %b busy %b want 0 0", start3_o, busy3_o); end
        @(negedge clk_p_i);
        reset_p_i = 1'b0;
        m = 5'($urandom);
        run_frame(m, 1, 1'b0, 1'b0, f);
        w = f.b7;
        checks++; if (w !== model_soft(model_cw(m), 7)) begin failures++; $display("FAIL rst_next_word: msg %b got %h want %h", m, w, model_soft(model_cw(m), 7)); end
        checks++; if (f.st7 !== 11'h780) begin failures++; $display("FAIL rst_next_timing: got %h want 780", f.st7); end
        $display("test_reset_mid_send next msg=%b", m);
    endtask

    task automatic test_loopback();
        frame_t f;
        logic [4:0]  m;
        logic [83:0] w;
        int errs;
        errs = 0;
        for (int n = 0; n < 160; n++) begin
            m = 5'($urandom);
            run_frame(m, int'($urandom_range(0, 3)), 1'b0, 1'b1, f);
            w = f.b7;
            checks++; if (w !== model_soft(model_cw(m), 7) || f.acc !== 1'b1) begin failures++; errs++; $display("FAIL loop_word[%0d]: msg %b got %h want %h", n, m, w, model_soft(model_cw(m), 7)); end
            checks++; if (hard_decode(w) !== m) begin failures++; errs++; $display("FAIL loop_decode[%0d]: got %b want %b", n, hard_decode(w), m); end
            $display("loopback frame %0d msg=%b decoded=%b", n, m, hard_decode(w));
        end
        valid_i = 1'b0;
        $display("test_loopback errors=%0d", errs);
    endtask

    task automatic test_soft_mag3();
        frame_t f;
        logic [83:0] w3;
        logic [20:0] c;
        c = model_cw(5'b11111);
        run_frame(5'b11111, 0, 1'b0, 1'b0, f);
        w3 = f.b3;
        checks++; if (w3 !== model_soft(c, 3)) begin failures++; $display("FAIL mag3_word: got %h want %h", w3, model_soft(c, 3)); end
        checks++; if (w3[63:60] !== (c[15] ? 4'b1101 : 4'b0011)) begin failures++; $display("FAIL mag3_tail_u1: got %b want %b", w3[63:60], (c[15] ? 4'b1101 : 4'b0011)); end
        checks++; if (f.st3 !== 11'h780 || f.post_start3 !== 1'b0) begin failures++; $display("FAIL mag3_timing: st %h post %b want 780 0", f.st3, f.post_start3); end
        $display("test_soft_mag3 word=%h", w3);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_p_i = 1'b1;
        valid_i   = 1'b0;
        msg_i     = 5'b0;
        done_i    = 1'b0;
        test_reset();
        test_zero_msg();
        test_single_one();
        test_done_ignored();
        test_reset_mid_send();
        test_loopback();
        test_soft_mag3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
